bus_hub_n: RTL and testbench
============================

BUS_HUB_N -- requirements
Module: bus_hub_n

Interface
REQ-001: The module SHALL have parameter NUM_DEVICES, default 4, giving the number of device ports (1..16).
REQ-002: The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of WAIT cycles before an access is aborted (1..65535).
REQ-003: The module SHALL have parameter DEFAULT_RDATA, default 32'h0000_0000, giving the read data returned on error.
REQ-004: The module SHALL use one clock, clk, and a synchronous active-high reset, rst; ports are listed below.
REQ-005: clk  input  1  system clock; every register updates on its rising edge.
REQ-006: rst  input  1  synchronous active-high reset.
REQ-007: host_address  input  32  request address.
REQ-008: host_data_write  input  32  write data.
REQ-009: host_write_mask  input  4  byte enables for writes.
REQ-010: host_ren / host_wen  input  1 each  read request / write request (level).
REQ-011: host_data_read  output  32  registered read data.
REQ-012: host_ready  output  1  one-cycle completion pulse.
REQ-013: host_error  output  1  asserted only together with host_ready; marks an unmapped access or a timeout.
REQ-014: device_address / device_data_write  output  32*NUM_DEVICES  per-device address and write data; device i occupies slice [32*i +: 32].
REQ-015: device_write_mask  output  4*NUM_DEVICES  per-device byte enables.
REQ-016: device_ren / device_wen  output  NUM_DEVICES  per-device read / write strobe.
REQ-017: device_ready / device_active  input  NUM_DEVICES  device done; device claims the current address (combinational decode).
REQ-018: device_data_read  input  32*NUM_DEVICES  per-device read data.

Function
REQ-019: The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-020: In IDLE, device_address SHALL equal host_address on every port; in WAIT and RESP it SHALL equal the latched address.
REQ-021: In IDLE, when host_ren or host_wen is 1, the block SHALL latch address, wdata, mask, direction and the select index, then go to WAIT; if both are 1, the access SHALL be a write.
REQ-022: The select index SHALL be the lowest-index set bit of device_active.
REQ-023: If device_active is all zero at acceptance, the block SHALL go to RESP with error set, host_data_read=DEFAULT_RDATA, and assert no device strobe.
REQ-024: In WAIT, only the selected device's ren or wen SHALL be 1, held until completion; all other strobes SHALL be 0.
REQ-025: device_write_mask SHALL carry the latched mask for writes and be 4'b0000 for reads.
REQ-026: When the selected device_ready is 1 in WAIT, the block SHALL capture that device's rdata (reads only) and go to RESP; ready from unselected devices SHALL be ignored.
REQ-027: A WAIT cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES without ready, the strobe SHALL drop and the block SHALL go to RESP with error set and DEFAULT_RDATA.
REQ-028: In RESP, host_ready SHALL be 1 for exactly one cycle and host_error SHALL be 1 if error is set; the next state SHALL be IDLE.
REQ-029: Minimum latency SHALL be 3 edges: request seen in IDLE at cycle 0, strobe in cycle 1 with same-cycle device_ready, host_ready in cycle 2.
REQ-030: host_data_read SHALL hold its last value except when updated in RESP; for writes it SHALL be unchanged.
REQ-031: A request still asserted in the IDLE cycle after RESP SHALL be accepted as a new access.

Reset
REQ-032: On rst, the FSM SHALL go to IDLE and all strobes, host_ready and host_error SHALL be 0 at the next edge.
REQ-033: On rst, host_data_read and the counter SHALL clear to 0.
REQ-034: Reset mid-access SHALL abort the access without a host_ready pulse.

Structure
REQ-035: Package bus_hub_pkg SHALL hold the state enum, the bus width constants (32 address/data, 4 mask) and the default error data constant.
REQ-036: Lowest-index selection SHALL be a sub-module named bus_hub_prio_enc, parametrised by NUM_DEVICES, outputting an index and a valid flag.

Verification
REQ-037: Read of device 2 (active=4'b0100, rdata2=32'hCAFE_0002, ready in first WAIT cycle) -> host_ready at cycle 2, host_data_read=32'hCAFE_0002, error=0, only device_ren[2] pulsed.
REQ-038: Write with mask 4'b0011 to device 0 while devices 1 and 3 are also ready -> only device_wen[0]=1 and device_write_mask[0]=4'b0011; host_ready after device 0 ready only.
REQ-039: Overlap active=4'b1010 -> device 1 selected.
REQ-040: Unmapped address (active=0) -> host_ready and host_error at cycle 1 after IDLE, host_data_read=DEFAULT_RDATA, no strobes.
REQ-041: TIMEOUT_CYCLES=8 with device never ready -> strobe high for 8 cycles, then host_ready=1 and host_error=1.
REQ-042: rst asserted during WAIT -> strobes 0 next edge, no host_ready; a following request completes normally.

Source files
------------

// File: rtl/bus_hub_pkg.sv
// Shared types and constants for the bus hub: FSM states, bus widths and
// the read data returned on a failed access.
package bus_hub_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Index width for a device count; a single device still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_hub_n_if.sv
// Host request/response signals and the flattened per-device buses.
// slave: the hub's view; master: the host and devices surrounding it.
interface bus_hub_n_if
   import bus_hub_pkg::*;
#(
   parameter int NUM_DEVICES = 4
);

   logic [ADDR_W-1:0]             host_address;
   logic [DATA_W-1:0]             host_data_write;
   logic [MASK_W-1:0]             host_write_mask;
   logic                          host_ren;
   logic                          host_wen;
   logic [DATA_W-1:0]             host_data_read;
   logic                          host_ready;
   logic                          host_error;

   logic [ADDR_W*NUM_DEVICES-1:0] device_address;
   logic [DATA_W*NUM_DEVICES-1:0] device_data_write;
   logic [MASK_W*NUM_DEVICES-1:0] device_write_mask;
   logic [NUM_DEVICES-1:0]        device_ren;
   logic [NUM_DEVICES-1:0]        device_wen;
   logic [NUM_DEVICES-1:0]        device_ready;
   logic [NUM_DEVICES-1:0]        device_active;
   logic [DATA_W*NUM_DEVICES-1:0] device_data_read;

   modport slave (
      input  host_address, host_data_write, host_write_mask, host_ren, host_wen,
      input  device_ready, device_active, device_data_read,
      output host_data_read, host_ready, host_error,
      output device_address, device_data_write, device_write_mask,
      output device_ren, device_wen
   );

   modport master (
      output host_address, host_data_write, host_write_mask, host_ren, host_wen,
      output device_ready, device_active, device_data_read,
      input  host_data_read, host_ready, host_error,
      input  device_address, device_data_write, device_write_mask,
      input  device_ren, device_wen
   );

endinterface

// File: rtl/bus_hub_prio_enc.sv
// Lowest-index priority encoder over the device claim lines.
module bus_hub_prio_enc
   import bus_hub_pkg::*;
#(
   parameter int NUM_DEVICES = 4,
   localparam int IDX_W      = idx_width(NUM_DEVICES)
) (
   input  logic [NUM_DEVICES-1:0] active,
   output logic [IDX_W-1:0]       idx,
   output logic                   valid
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
         if (active[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_hub_n.sv
// Single-host to N-device bus hub: decodes on device_active, forwards one
// access at a time, and answers the host with a one-cycle ready pulse.
module bus_hub_n
   import bus_hub_pkg::*;
#(
   parameter int                 NUM_DEVICES    = 4,
   parameter int                 TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]  DEFAULT_RDATA  = ERR_RDATA
) (
   input logic        clk,
   input logic        rst,
   bus_hub_n_if.slave bus
);

   localparam int               IDX_W    = idx_width(NUM_DEVICES);
   localparam int               CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q;
   state_e              state_d;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   mask_q;
   logic                write_q;
   logic [IDX_W-1:0]    sel_q;

   logic                err_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rdata_q;

   logic [IDX_W-1:0]    enc_idx;
   logic                enc_valid;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;

   logic                accept;
   logic                done_ok;
   logic                done_tmo;

   bus_hub_prio_enc #(
      .NUM_DEVICES (NUM_DEVICES)
   ) u_prio_enc (
      .active (bus.device_active),
      .idx    (enc_idx),
      .valid  (enc_valid)
   );

   // Ready and read data of the latched device only; other devices are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_ready = bus.device_ready[i];
            sel_rdata = bus.device_data_read[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      done_ok  = 1'b0;
      done_tmo = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.host_ren || bus.host_wen) begin
               accept  = 1'b1;
               state_d = enc_valid ? WAIT : RESP;
            end
         end
         WAIT: begin
            // A ready on the last allowed cycle still completes normally.
            if (sel_ready) begin
               done_ok = 1'b1;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               done_tmo = 1'b1;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: request payload needs no reset; it is only observed after an accept reloads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus.host_address;
         wdata_q <= bus.host_data_write;
         mask_q  <= bus.host_write_mask;
         write_q <= bus.host_wen;
         sel_q   <= enc_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         err_q <= !enc_valid;
         if (!enc_valid) begin
            rdata_q <= DEFAULT_RDATA;
         end
      end else if (done_ok) begin
         err_q <= 1'b0;
         if (!write_q) begin
            rdata_q <= sel_rdata;
         end
      end else if (done_tmo) begin
         err_q   <= 1'b1;
         rdata_q <= DEFAULT_RDATA;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Address and write data pass straight through while idle so devices can decode early.
   always_comb begin
      bus.device_address    = '0;
      bus.device_data_write = '0;
      bus.device_write_mask = '0;
      bus.device_ren        = '0;
      bus.device_wen        = '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
         if (state_q == IDLE) begin
            bus.device_address[ADDR_W*i +: ADDR_W]    = bus.host_address;
            bus.device_data_write[DATA_W*i +: DATA_W] = bus.host_data_write;
         end else begin
            bus.device_address[ADDR_W*i +: ADDR_W]    = addr_q;
            bus.device_data_write[DATA_W*i +: DATA_W] = wdata_q;
            if (write_q) begin
               bus.device_write_mask[MASK_W*i +: MASK_W] = mask_q;
            end
         end
         if (state_q == WAIT && sel_q == IDX_W'(i)) begin
            bus.device_ren[i] = !write_q;
            bus.device_wen[i] = write_q;
         end
      end
   end

   assign bus.host_ready     = (state_q == RESP);
   assign bus.host_error     = (state_q == RESP) && err_q;
   assign bus.host_data_read = rdata_q;

endmodule

// File: tb/tb_bus_hub_n.sv
// Self-checking bench for bus_hub_n: directed corner cases plus randomized
// accesses compared against a transaction-level expectation.
module tb_bus_hub_n;
   import bus_hub_pkg::*;

   localparam int          N        = 4;
   localparam int          TMO      = 8;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_hub_n_if #(.NUM_DEVICES(N)) bus ();

   bus_hub_n #(
      .NUM_DEVICES    (N),
      .TIMEOUT_CYCLES (TMO),
      .DEFAULT_RDATA  (ERR_DATA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_hdr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Lowest set bit isolated arithmetically, then converted to its index.
   function automatic int lowest(input logic [3:0] act);
      logic [3:0] iso;
      iso = act & (~act + 4'd1);
      return $clog2(iso);
   endfunction

   task automatic idle_inputs();
      bus.host_address     = '0;
      bus.host_data_write  = '0;
      bus.host_write_mask  = '0;
      bus.host_ren         = 1'b0;
      bus.host_wen         = 1'b0;
      bus.device_ready     = '0;
      bus.device_active    = '0;
      bus.device_data_read = '0;
   endtask

   // Starts at a falling edge with the hub idle; returns at a falling edge with it idle again.
   task automatic run_access(input string tag, input logic ren, input logic wen,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input logic [3:0] active,
                             input logic [3:0] noise, input int delay,
                             input logic [31:0] sel_data);
      logic [31:0] rd [N];
      logic [3:0]  one_hot;
      logic [7:0]  exp_strb;
      bit          wr, mapped, ok, exp_err;
      int          sel, nwait;

      wr      = wen;
      mapped  = (active != 4'd0);
      sel     = mapped ? lowest(active) : 0;
      one_hot = mapped ? (4'd1 << sel) : 4'd0;
      for (int i = 0; i < N; i++) rd[i] = $urandom;
      if (mapped) rd[sel] = sel_data;

      bus.host_address    = addr;
      bus.host_data_write = wdata;
      bus.host_write_mask = mask;
      bus.host_ren        = ren;
      bus.host_wen        = wen;
      bus.device_active   = active;
      bus.device_ready    = noise & ~one_hot;
      for (int i = 0; i < N; i++) bus.device_data_read[32*i +: 32] = rd[i];
      #1;
      check({tag, ".idle_addr"}, bus.device_address[32*(N-1) +: 32], addr);
      check({tag, ".idle_ready"}, 32'(bus.host_ready), 32'd0);

      @(negedge clk);
      bus.host_ren      = 1'b0;
      bus.host_wen      = 1'b0;
      bus.host_address  = $urandom;
      bus.device_active = 4'($urandom);

      if (mapped) begin
         ok       = (delay < TMO);
         nwait    = ok ? delay + 1 : TMO;
         exp_strb = wr ? {one_hot, 4'd0} : {4'd0, one_hot};
         for (int n = 0; n < nwait; n++) begin
            check({tag, ".strobe"}, 32'({bus.device_wen, bus.device_ren}), 32'(exp_strb));
            check({tag, ".mask"}, 32'(bus.device_write_mask[4*sel +: 4]), 32'(wr ? mask : 4'd0));
            check({tag, ".wait_addr"}, bus.device_address[32*sel +: 32], addr);
            check({tag, ".wait_ready"}, 32'(bus.host_ready), 32'd0);
            bus.device_ready = (noise & ~one_hot) | ((n >= delay) ? one_hot : 4'd0);
            @(negedge clk);
         end
         exp_err = !ok;
         if (!ok) exp_hdr = ERR_DATA;
         else if (!wr) exp_hdr = rd[sel];
      end else begin
         exp_err = 1'b1;
         exp_hdr = ERR_DATA;
      end

      check({tag, ".resp_ready"}, 32'(bus.host_ready), 32'd1);
      check({tag, ".resp_error"}, 32'(bus.host_error), 32'(exp_err));
      check({tag, ".resp_data"}, bus.host_data_read, exp_hdr);
      check({tag, ".resp_strobe"}, 32'({bus.device_wen, bus.device_ren}), 32'd0);

      bus.device_ready = '0;
      @(negedge clk);
      check({tag, ".pulse_end"}, 32'({bus.host_ready, bus.host_error}), 32'd0);
      check({tag, ".data_hold"}, bus.host_data_read, exp_hdr);
   endtask

   initial begin
      logic [4:0] seen;

      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      exp_hdr = 32'd0;
      check("reset.ready_error", 32'({bus.host_ready, bus.host_error}), 32'd0);
      check("reset.strobe", 32'({bus.device_wen, bus.device_ren}), 32'd0);
      check("reset.data", bus.host_data_read, exp_hdr);
      rst = 1'b0;
      @(negedge clk);

      run_access("rd_dev2", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 4'b0100, 4'b0000, 0, 32'hCAFE_0002);
      run_access("wr_dev0", 1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 4'b0011, 4'b1011, 4'b1010, 2, 32'h0);
      run_access("overlap", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 4'b1010, 4'b0000, 1, 32'h5A5A_0001);
      run_access("unmapped", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 4'b0000, 4'b1111, 0, 32'h0);
      run_access("timeout", 1'b0, 1'b1, 32'h0000_4000, 32'hABCD_0000, 4'b1100, 4'b1000, 4'b0111, 1000, 32'h0);
      run_access("last_cycle", 1'b1, 1'b0, 32'h0000_4004, 32'h0, 4'h0, 4'b0010, 4'b0000, TMO - 1, 32'h0BAD_F00D);
      run_access("both_is_wr", 1'b1, 1'b1, 32'h0000_5000, 32'h7777_8888, 4'b0101, 4'b0110, 4'b0000, 0, 32'h0);

      // A request held high through RESP is accepted again in the following idle cycle.
      bus.host_address     = 32'h0000_0100;
      bus.host_ren         = 1'b1;
      bus.device_active    = 4'b0001;
      bus.device_ready     = 4'b0001;
      bus.device_data_read = '0;
      bus.device_data_read[31:0] = 32'h1234_5678;
      seen = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         seen = {seen[3:0], bus.host_ready};
      end
      check("b2b.ready_pattern", 32'(seen), 32'(5'b01001));
      bus.host_ren = 1'b0;
      exp_hdr = 32'h1234_5678;
      check("b2b.data", bus.host_data_read, exp_hdr);
      idle_inputs();
      @(negedge clk);

      // Reset while the strobe is up aborts silently and clears the read data.
      bus.host_ren      = 1'b1;
      bus.host_address  = 32'h0000_0200;
      bus.device_active = 4'b0010;
      @(negedge clk);
      bus.host_ren = 1'b0;
      check("rst_wait.strobe_on", 32'(bus.device_ren), 32'(4'b0010));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_hdr = 32'd0;
      check("rst_wait.strobe_off", 32'({bus.device_wen, bus.device_ren}), 32'd0);
      check("rst_wait.no_ready", 32'(bus.host_ready), 32'd0);
      check("rst_wait.data", bus.host_data_read, exp_hdr);
      @(negedge clk);
      check("rst_wait.still_quiet", 32'(bus.host_ready), 32'd0);
      idle_inputs();
      run_access("after_rst", 1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 4'b0010, 4'b0000, 3, 32'h0600_D001);

      for (int t = 0; t < 24; t++) begin
         int          kind;
         logic [31:0] rdv;
         kind = $urandom_range(0, 2);
         rdv  = $urandom;
         run_access($sformatf("rand%0d", t), kind != 1, kind != 0, $urandom, $urandom,
                    4'($urandom), 4'($urandom_range(0, 15)), 4'($urandom),
                    $urandom_range(0, 10), rdv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
